// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller: FSM states,
// opcode/funct values, ALU codes, instruction classes and fault codes.
package mc_pkg;

    localparam int OPC_W = 6;
    localparam int ALU_W = 3;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE   = 3'd0,
        C_ALUI    = 3'd1,
        C_LW      = 3'd2,
        C_SW      = 3'd3,
        C_BRANCH  = 3'd4,
        C_JUMP    = 3'd5,
        C_HALT    = 3'd6,
        C_ILLEGAL = 3'd7
    } inst_cls_t;

    typedef enum logic [1:0] {
        BR_EQ  = 2'd0,
        BR_NE  = 2'd1,
        BR_LTZ = 2'd2
    } br_kind_t;

    localparam logic [OPC_W-1:0] OP_RTYPE  = 6'b000000;
    localparam logic [OPC_W-1:0] OP_REGIMM = 6'b000001;
    localparam logic [OPC_W-1:0] OP_J      = 6'b000010;
    localparam logic [OPC_W-1:0] OP_BEQ    = 6'b000100;
    localparam logic [OPC_W-1:0] OP_BNE    = 6'b000101;
    localparam logic [OPC_W-1:0] OP_ADDIU  = 6'b001001;
    localparam logic [OPC_W-1:0] OP_SLTI   = 6'b001010;
    localparam logic [OPC_W-1:0] OP_ANDI   = 6'b001100;
    localparam logic [OPC_W-1:0] OP_ORI    = 6'b001101;
    localparam logic [OPC_W-1:0] OP_LW     = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW     = 6'b101011;

    localparam logic [OPC_W-1:0] FN_SLL = 6'b000000;
    localparam logic [OPC_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OPC_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OPC_W-1:0] FN_AND = 6'b100100;
    localparam logic [OPC_W-1:0] FN_OR  = 6'b100101;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SLL = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b100;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ILLEGAL = 2'b01;
    localparam logic [1:0] FLT_MEM_TMO = 2'b10;

    localparam logic [1:0] PCS_SEQ    = 2'b00;
    localparam logic [1:0] PCS_BRANCH = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b11;

    function automatic logic branch_taken(input logic [1:0] kind, input logic zero,
                                          input logic sign);
        case (kind)
            BR_EQ:   return zero;
            BR_NE:   return ~zero;
            default: return sign;
        endcase
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: op/funct -> class, branch kind and EXE-stage ALU fields.
// Anything outside the supported subset comes out as C_ILLEGAL.
module mc_decode
    import mc_pkg::*;
#(
    parameter logic [OPC_W-1:0] HALT_OP = 6'b111111
) (
    input  logic [OPC_W-1:0] i_op,
    input  logic [OPC_W-1:0] i_funct,
    output logic [2:0]       o_cls,
    output logic [1:0]       o_br_kind,
    output logic [ALU_W-1:0] o_alu_ctr,
    output logic             o_alu_src_a,
    output logic             o_alu_src_b,
    output logic             o_ext_op
);

    always_comb begin
        o_cls       = C_ILLEGAL;
        o_br_kind   = BR_EQ;
        o_alu_ctr   = ALU_ADD;
        o_alu_src_a = 1'b1;
        o_alu_src_b = 1'b0;
        o_ext_op    = 1'b0;
        if (i_op == HALT_OP) begin
            o_cls = C_HALT;
        end else begin
            case (i_op)
                OP_RTYPE: begin
                    o_alu_src_b = 1'b1;
                    case (i_funct)
                        FN_ADD: begin o_cls = C_RTYPE; o_alu_ctr = ALU_ADD; end
                        FN_SUB: begin o_cls = C_RTYPE; o_alu_ctr = ALU_SUB; end
                        FN_AND: begin o_cls = C_RTYPE; o_alu_ctr = ALU_AND; end
                        FN_OR:  begin o_cls = C_RTYPE; o_alu_ctr = ALU_OR;  end
                        FN_SLL: begin
                            o_cls       = C_RTYPE;
                            o_alu_ctr   = ALU_SLL;
                            o_alu_src_a = 1'b0;
                        end
                        default: o_cls = C_ILLEGAL;
                    endcase
                end
                OP_J: o_cls = C_JUMP;
                OP_BEQ, OP_BNE: begin
                    o_cls       = C_BRANCH;
                    o_br_kind   = (i_op == OP_BEQ) ? BR_EQ : BR_NE;
                    o_alu_ctr   = ALU_SUB;
                    o_alu_src_b = 1'b1;
                    o_ext_op    = 1'b1;
                end
                // bltz compares rs against rt, which is r0 in the REGIMM encoding
                OP_REGIMM: begin
                    o_cls       = C_BRANCH;
                    o_br_kind   = BR_LTZ;
                    o_alu_ctr   = ALU_SLT;
                    o_alu_src_b = 1'b1;
                    o_ext_op    = 1'b1;
                end
                OP_ADDIU: begin o_cls = C_ALUI; o_alu_ctr = ALU_ADD; o_ext_op = 1'b1; end
                OP_SLTI:  begin o_cls = C_ALUI; o_alu_ctr = ALU_SLT; o_ext_op = 1'b1; end
                OP_ANDI:  begin o_cls = C_ALUI; o_alu_ctr = ALU_AND; end
                OP_ORI:   begin o_cls = C_ALUI; o_alu_ctr = ALU_OR;  end
                OP_LW:    begin o_cls = C_LW;   o_ext_op = 1'b1; end
                OP_SW:    begin o_cls = C_SW;   o_ext_op = 1'b1; end
                default:  o_cls = C_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-subset control FSM (IF/ID/EXE/MEM/WB/HALT) with memory-ready timeout,
// sticky fault code and retired-instruction counter. j 2, branch 3, ALU 4, sw 4+w, lw 5+w cycles.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int              OP_W      = 6,
    parameter int              ALU_CTR_W = 3,
    parameter int              CNT_W     = 32,
    parameter int              MEM_TMO   = 15,
    parameter logic [OP_W-1:0] HALT_OP   = 6'b111111
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [OP_W-1:0]      i_op,
    input  logic [OP_W-1:0]      i_funct,
    input  logic                 i_zero,
    input  logic                 i_sign,
    input  logic                 i_mem_ready,
    output logic                 o_ir_wrt,
    output logic                 o_pc_wrt,
    output logic [1:0]           o_pc_src,
    output logic                 o_reg_wrt,
    output logic                 o_reg_dst,
    output logic                 o_mem_to_reg,
    output logic                 o_alu_src_a,
    output logic                 o_alu_src_b,
    output logic                 o_ext_op,
    output logic [ALU_CTR_W-1:0] o_alu_ctr,
    output logic                 o_mem_rd,
    output logic                 o_mem_wrt,
    output logic                 o_halted,
    output logic [1:0]           o_fault,
    output logic [CNT_W-1:0]     o_retired
);

    localparam int WAIT_W = (MEM_TMO > 0) ? $clog2(MEM_TMO + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TMO > 0) ? MEM_TMO - 1 : 0);

    state_t                 r_state;
    logic [WAIT_W-1:0]      r_wait;
    logic [CNT_W-1:0]       r_retired;
    logic                   r_reg_wrt;
    logic                   r_reg_dst;
    logic                   r_mem_to_reg;
    logic                   r_alu_src_a;
    logic                   r_alu_src_b;
    logic                   r_ext_op;
    logic [ALU_CTR_W-1:0]   r_alu_ctr;
    logic                   r_mem_rd;
    logic                   r_mem_wrt;
    logic                   r_halted;
    logic [1:0]             r_fault;

    logic [2:0]             w_cls;
    logic [1:0]             w_br_kind;
    logic [ALU_W-1:0]       w_alu_ctr;
    logic                   w_alu_src_a;
    logic                   w_alu_src_b;
    logic                   w_ext_op;
    logic                   w_jump_id;
    logic                   w_branch_exe;
    logic                   w_taken;
    logic                   w_mem_tmo;

    mc_decode #(
        .HALT_OP (HALT_OP)
    ) u_decode (
        .i_op        (i_op),
        .i_funct     (i_funct),
        .o_cls       (w_cls),
        .o_br_kind   (w_br_kind),
        .o_alu_ctr   (w_alu_ctr),
        .o_alu_src_a (w_alu_src_a),
        .o_alu_src_b (w_alu_src_b),
        .o_ext_op    (w_ext_op)
    );

    assign w_jump_id    = (r_state == S_ID) && (w_cls == C_JUMP);
    assign w_branch_exe = (r_state == S_EXE) && (w_cls == C_BRANCH);
    assign w_taken      = branch_taken(w_br_kind, i_zero, i_sign);
    assign w_mem_tmo    = (MEM_TMO != 0) && (r_wait == WAIT_LAST);

    // PC path depends on the IR (j in ID) and on ALU flags (branch in EXE), so it is not registered.
    assign o_ir_wrt = !i_rst && (r_state == S_IF);
    assign o_pc_wrt = !i_rst && ((r_state == S_IF) || w_jump_id || (w_branch_exe && w_taken));
    assign o_pc_src = i_rst        ? PCS_SEQ    :
                      w_jump_id    ? PCS_JUMP   :
                      w_branch_exe ? PCS_BRANCH : PCS_SEQ;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IF;
            r_wait       <= '0;
            r_retired    <= '0;
            r_reg_wrt    <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src_a  <= 1'b0;
            r_alu_src_b  <= 1'b0;
            r_ext_op     <= 1'b0;
            r_alu_ctr    <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_wrt    <= 1'b0;
            r_halted     <= 1'b0;
            r_fault      <= FLT_NONE;
        end else begin
            r_reg_wrt    <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src_a  <= 1'b0;
            r_alu_src_b  <= 1'b0;
            r_ext_op     <= 1'b0;
            r_alu_ctr    <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_wrt    <= 1'b0;
            case (r_state)
                S_IF: r_state <= S_ID;
                S_ID: begin
                    if (w_cls == C_JUMP) begin
                        r_state   <= S_IF;
                        r_retired <= r_retired + CNT_W'(1);
                    end else if (w_cls == C_HALT || w_cls == C_ILLEGAL) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        if (w_cls == C_ILLEGAL && r_fault == FLT_NONE)
                            r_fault <= FLT_ILLEGAL;
                    end else begin
                        r_state     <= S_EXE;
                        r_alu_ctr   <= ALU_CTR_W'(w_alu_ctr);
                        r_alu_src_a <= w_alu_src_a;
                        r_alu_src_b <= w_alu_src_b;
                        r_ext_op    <= w_ext_op;
                    end
                end
                S_EXE: begin
                    if (w_cls == C_BRANCH) begin
                        r_state   <= S_IF;
                        r_retired <= r_retired + CNT_W'(1);
                    end else if (w_cls == C_LW || w_cls == C_SW) begin
                        r_state   <= S_MEM;
                        r_wait    <= '0;
                        r_mem_rd  <= (w_cls == C_LW);
                        r_mem_wrt <= (w_cls == C_SW);
                    end else begin
                        r_state   <= S_WB;
                        r_reg_wrt <= 1'b1;
                        r_reg_dst <= (w_cls == C_RTYPE);
                    end
                end
                S_MEM: begin
                    // A ready on the final allowed cycle still completes the access.
                    if (i_mem_ready) begin
                        if (w_cls == C_SW) begin
                            r_state   <= S_IF;
                            r_retired <= r_retired + CNT_W'(1);
                        end else begin
                            r_state      <= S_WB;
                            r_reg_wrt    <= 1'b1;
                            r_mem_to_reg <= 1'b1;
                        end
                    end else if (w_mem_tmo) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        if (r_fault == FLT_NONE)
                            r_fault <= FLT_MEM_TMO;
                    end else begin
                        r_wait    <= r_wait + WAIT_W'(1);
                        r_mem_rd  <= r_mem_rd;
                        r_mem_wrt <= r_mem_wrt;
                    end
                end
                S_WB: begin
                    r_state   <= S_IF;
                    r_retired <= r_retired + CNT_W'(1);
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IF;
            endcase
        end
    end

    assign o_reg_wrt    = r_reg_wrt;
    assign o_reg_dst    = r_reg_dst;
    assign o_mem_to_reg = r_mem_to_reg;
    assign o_alu_src_a  = r_alu_src_a;
    assign o_alu_src_b  = r_alu_src_b;
    assign o_ext_op     = r_ext_op;
    assign o_alu_ctr    = r_alu_ctr;
    assign o_mem_rd     = r_mem_rd;
    assign o_mem_wrt    = r_mem_wrt;
    assign o_halted     = r_halted;
    assign o_fault      = r_fault;
    assign o_retired    = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: per-instruction expected cycle plans built from the instruction's class,
// checked every cycle, plus literal latency/fault/counter expectations.
module tb_multicycle_controller;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op_d = '0;
    logic [5:0] funct_d = '0;
    logic       zero_d = 1'b0;
    logic       sign_d = 1'b0;
    logic       rdy_d = 1'b0;

    logic       o_ir_wrt, o_pc_wrt, o_reg_wrt, o_reg_dst, o_mem_to_reg;
    logic       o_alu_src_a, o_alu_src_b, o_ext_op, o_mem_rd, o_mem_wrt, o_halted;
    logic [1:0] o_pc_src, o_fault;
    logic [2:0] o_alu_ctr;
    logic [3:0] o_retired;

    always #5 clk = ~clk;

    multicycle_controller #(
        .OP_W(6), .ALU_CTR_W(3), .CNT_W(4), .MEM_TMO(TMO), .HALT_OP(6'b111111)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_op(op_d), .i_funct(funct_d), .i_zero(zero_d),
        .i_sign(sign_d), .i_mem_ready(rdy_d), .o_ir_wrt(o_ir_wrt), .o_pc_wrt(o_pc_wrt),
        .o_pc_src(o_pc_src), .o_reg_wrt(o_reg_wrt), .o_reg_dst(o_reg_dst),
        .o_mem_to_reg(o_mem_to_reg), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
        .o_ext_op(o_ext_op), .o_alu_ctr(o_alu_ctr), .o_mem_rd(o_mem_rd),
        .o_mem_wrt(o_mem_wrt), .o_halted(o_halted), .o_fault(o_fault), .o_retired(o_retired)
    );

    typedef struct packed {
        logic       ir_wrt;
        logic       pc_wrt;
        logic [1:0] pc_src;
        logic       reg_wrt;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       ext_op;
        logic [2:0] alu_ctr;
        logic       mem_rd;
        logic       mem_wrt;
        logic       halted;
        logic [1:0] fault;
        logic [3:0] retired;
    } obs_t;

    typedef struct packed {
        logic chk;
        obs_t o;
    } exp_t;

    obs_t act;
    assign act = {o_ir_wrt, o_pc_wrt, o_pc_src, o_reg_wrt, o_reg_dst, o_mem_to_reg,
                  o_alu_src_a, o_alu_src_b, o_ext_op, o_alu_ctr, o_mem_rd, o_mem_wrt,
                  o_halted, o_fault, o_retired};

    exp_t exp_q[$];
    obs_t plan[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    int         m_ret = 0;
    logic [1:0] m_fault = 2'b00;
    logic       rdy_noise = 1'b0;

    int   n_rd, n_wr, wb_idx, first_ret;
    logic wb_dst, wb_m2r, exe_pcw;
    logic [1:0] exe_src;
    obs_t last_obs;
    int   rst_rd, rst_ret, rst_irw;
    int   wrap_ret[18];

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            if (cur.chk) begin
                checks++;
                if (act !== cur.o) begin
                    errors++;
                    $display("FAIL cycle_model t=%0t got %h expected %h", $time, act, cur.o);
                end
            end
        end
    end

    task automatic lit(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, req);
        end
    endtask

    // 0 R-type, 1 ALU-imm, 2 lw, 3 sw, 4 branch, 5 j, 6 halt, 7 illegal
    function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h3f) return 6;
        case (op)
            6'h00:   return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                             fn == 6'h25 || fn == 6'h00) ? 0 : 7;
            6'h02:   return 5;
            6'h01, 6'h04, 6'h05: return 4;
            6'h09, 6'h0a, 6'h0c, 6'h0d: return 1;
            6'h23:   return 2;
            6'h2b:   return 3;
            default: return 7;
        endcase
    endfunction

    function automatic obs_t base();
        obs_t b = '0;
        b.fault   = m_fault;
        b.retired = 4'(m_ret);
        return b;
    endfunction

    task automatic push_halt();
        obs_t b;
        for (int i = 0; i < 3; i++) begin
            b = base();
            b.halted = 1'b1;
            plan.push_back(b);
        end
    endtask

    // Builds the whole expected cycle sequence of one instruction and advances the model.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input logic s, input int w);
        obs_t b;
        int c;
        int n;
        c = cls_of(op, fn);
        plan.delete();
        b = base(); b.ir_wrt = 1'b1; b.pc_wrt = 1'b1;
        plan.push_back(b);
        b = base();
        if (c == 5) begin
            b.pc_wrt = 1'b1; b.pc_src = 2'b11;
            plan.push_back(b);
            m_ret = (m_ret + 1) % 16;
            return;
        end
        plan.push_back(b);
        if (c >= 6) begin
            if (c == 7 && m_fault == 2'b00) m_fault = 2'b01;
            push_halt();
            return;
        end
        b = base();
        b.alu_src_a = 1'b1;
        b.alu_src_b = (c == 0 || c == 4);
        b.ext_op    = !(op == 6'h00 || op == 6'h0c || op == 6'h0d);
        case (op)
            6'h00: case (fn)
                       6'h22:   b.alu_ctr = 3'b001;
                       6'h24:   b.alu_ctr = 3'b100;
                       6'h25:   b.alu_ctr = 3'b011;
                       6'h00:   begin b.alu_ctr = 3'b010; b.alu_src_a = 1'b0; end
                       default: b.alu_ctr = 3'b000;
                   endcase
            6'h04, 6'h05: b.alu_ctr = 3'b001;
            6'h01, 6'h0a: b.alu_ctr = 3'b101;
            6'h0c:   b.alu_ctr = 3'b100;
            6'h0d:   b.alu_ctr = 3'b011;
            default: b.alu_ctr = 3'b000;
        endcase
        if (c == 4) begin
            b.pc_src = 2'b01;
            b.pc_wrt = (op == 6'h04) ? z : (op == 6'h05) ? !z : s;
            plan.push_back(b);
            m_ret = (m_ret + 1) % 16;
            return;
        end
        plan.push_back(b);
        if (c == 2 || c == 3) begin
            n = (w < TMO) ? w + 1 : TMO;
            for (int i = 0; i < n; i++) begin
                b = base();
                b.mem_rd  = (c == 2);
                b.mem_wrt = (c == 3);
                plan.push_back(b);
            end
            if (w >= TMO) begin
                if (m_fault == 2'b00) m_fault = 2'b10;
                push_halt();
                return;
            end
            if (c == 3) begin
                m_ret = (m_ret + 1) % 16;
                return;
            end
        end
        b = base();
        b.reg_wrt    = 1'b1;
        b.reg_dst    = (c == 0);
        b.mem_to_reg = (c == 2);
        plan.push_back(b);
        m_ret = (m_ret + 1) % 16;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input logic s, input int w, input int maxc);
        exp_t e;
        int   c;
        c = cls_of(op, fn);
        build(op, fn, z, s, w);
        n_rd = 0; n_wr = 0; wb_idx = -1; first_ret = -1;
        wb_dst = 1'b0; wb_m2r = 1'b0; exe_pcw = 1'b0; exe_src = 2'b00;
        for (int k = 0; k < plan.size(); k++) begin
            if (maxc != 0 && k >= maxc) break;
            @(posedge clk); #1;
            rst = 1'b0; op_d = op; funct_d = fn; zero_d = z; sign_d = s;
            rdy_d = (c == 2 || c == 3) ? (k == 3 + w) : rdy_noise;
            e.chk = 1'b1; e.o = plan[k];
            exp_q.push_back(e);
            @(negedge clk); #1;
            if (k == 0) first_ret = int'(o_retired);
            if (o_mem_rd) n_rd++;
            if (o_mem_wrt) n_wr++;
            if (o_reg_wrt && wb_idx < 0) begin
                wb_idx = k; wb_dst = o_reg_dst; wb_m2r = o_mem_to_reg;
            end
            if (k == 2) begin exe_pcw = o_pc_wrt; exe_src = o_pc_src; end
            last_obs = act;
        end
    endtask

    task automatic reset_dut();
        exp_t e;
        @(posedge clk); #1;
        rst = 1'b1; rdy_d = 1'b0;
        e.chk = 1'b0; e.o = '0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        m_ret = 0; m_fault = 2'b00;
        e.chk = 1'b1; e.o = base();
        exp_q.push_back(e);
        @(negedge clk); #1;
        rst_rd = int'(o_mem_rd); rst_ret = int'(o_retired); rst_irw = int'(o_ir_wrt);
    endtask

    initial begin
        reset_dut();
        lit("reset_retired", rst_ret, 0);
        lit("reset_ir_wrt", rst_irw, 0);

        rdy_noise = 1'b1;
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, 0, 0);          // add
        lit("add_wb_cycle", wb_idx, 3);
        lit("add_reg_dst", int'(wb_dst), 1);
        run_instr(6'h00, 6'h22, 1'b1, 1'b0, 0, 0);          // sub
        lit("add_retired", first_ret, 1);
        rdy_noise = 1'b0;
        run_instr(6'h00, 6'h25, 1'b0, 1'b0, 0, 0);          // or
        run_instr(6'h00, 6'h24, 1'b0, 1'b1, 0, 0);          // and
        run_instr(6'h00, 6'h00, 1'b0, 1'b0, 0, 0);          // sll
        run_instr(6'h09, 6'h15, 1'b0, 1'b0, 0, 0);          // addiu
        run_instr(6'h0c, 6'h00, 1'b0, 1'b0, 0, 0);          // andi
        run_instr(6'h0d, 6'h3f, 1'b0, 1'b0, 0, 0);          // ori
        run_instr(6'h0a, 6'h00, 1'b0, 1'b0, 0, 0);          // slti

        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 3, 0);          // lw, 3 wait cycles
        lit("lw_mem_rd_cycles", n_rd, 4);
        lit("lw_wb_cycle", wb_idx, 7);
        lit("lw_mem_to_reg", int'(wb_m2r), 1);
        run_instr(6'h2b, 6'h00, 1'b0, 1'b0, 0, 0);          // sw, immediate ready
        lit("sw_mem_wrt_cycles", n_wr, 1);
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 0, 0);

        run_instr(6'h04, 6'h00, 1'b1, 1'b0, 0, 0);          // beq taken
        lit("beq_taken_pc_wrt", int'(exe_pcw), 1);
        lit("beq_pc_src", int'(exe_src), 1);
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, 0, 0);          // beq not taken
        lit("beq_not_taken_pc_wrt", int'(exe_pcw), 0);
        run_instr(6'h05, 6'h00, 1'b1, 1'b0, 0, 0);          // bne not taken
        run_instr(6'h01, 6'h00, 1'b0, 1'b1, 0, 0);          // bltz taken
        lit("bltz_taken_pc_wrt", int'(exe_pcw), 1);
        run_instr(6'h01, 6'h00, 1'b0, 1'b0, 0, 0);          // bltz not taken
        run_instr(6'h02, 6'h00, 1'b0, 1'b0, 0, 0);          // j

        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 99, 5);         // lw cut off in MEM
        reset_dut();
        lit("rst_mid_mem_mem_rd", rst_rd, 0);
        lit("rst_mid_mem_retired", rst_ret, 0);

        for (int i = 0; i < 18; i++) begin
            run_instr(6'h02, 6'h00, 1'b0, 1'b0, 0, 0);
            wrap_ret[i] = first_ret;
        end
        lit("retired_before_wrap", wrap_ret[15], 15);
        lit("retired_wrap_0", wrap_ret[16], 0);
        lit("retired_wrap_1", wrap_ret[17], 1);

        run_instr(6'h2b, 6'h00, 1'b0, 1'b0, 99, 0);         // sw, memory never ready
        lit("tmo_mem_wrt_cycles", n_wr, 15);
        lit("tmo_fault", int'(last_obs.fault), 2);
        lit("tmo_mem_wrt_dropped", int'(last_obs.mem_wrt), 0);
        reset_dut();

        run_instr(6'h10, 6'h00, 1'b0, 1'b0, 0, 0);          // unknown opcode
        lit("illegal_op_fault", int'(last_obs.fault), 1);
        lit("illegal_op_halted", int'(last_obs.halted), 1);
        reset_dut();
        run_instr(6'h00, 6'h2a, 1'b0, 1'b0, 0, 0);          // unsupported funct
        lit("illegal_funct_fault", int'(last_obs.fault), 1);
        reset_dut();
        run_instr(6'h3f, 6'h00, 1'b0, 1'b0, 0, 0);          // halt
        lit("halt_halted", int'(last_obs.halted), 1);
        lit("halt_fault", int'(last_obs.fault), 0);
        reset_dut();
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, 0, 0);
        lit("after_halt_rst_add_wb", wb_idx, 3);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
